// File: rtl/cpu_core_pkg.sv
// Shared widths, fetch-state encoding and address helpers for the cpu_core fetch path.
package cpu_core_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned PC_STEP = 4;
  localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with a synchronous flush; the head reads as zero while empty.
module fetch_fifo
  import cpu_core_pkg::*;
#(
  parameter int unsigned WIDTH = ENTRY_W,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             head_valid_o,
  output logic [PTR_W:0]   count_o
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_push = push_i && (count_q != FULL_COUNT);
    do_pop  = pop_i && (count_q != '0);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; the empty-gated head keeps stale entries invisible.
  always_ff @(posedge CLK) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_comb begin
    head_valid_o = (count_q != '0);
    head_o       = head_valid_o ? mem_q[rd_ptr_q] : '0;
    count_o      = count_q;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, issues word reads, buffers words and handles redirects.
module instr_fetch_unit
  import cpu_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [31:0] IMEM_ADDRESS,
  output logic        IMEM_READ,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_BUSYWAIT,
  input  logic        REDIRECT_VALID,
  input  logic [31:0] REDIRECT_PC,
  output logic        INSTR_VALID,
  output logic [31:0] INSTR,
  output logic [31:0] INSTR_PC,
  input  logic        INSTR_READY
);

  localparam int unsigned CNT_W = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [ADDR_W-1:0] pending_pc_q;
  logic              run_q;

  logic [ADDR_W-1:0]  redirect_target;
  logic               imem_read;
  logic               accept;
  logic               fifo_flush;
  logic               fifo_push;
  logic               fifo_pop;
  logic [ENTRY_W-1:0] fifo_head;
  logic               fifo_head_valid;
  logic [CNT_W-1:0]   fifo_count;

  // run_q keeps the read request low while reset is held and comes up one edge
  // after release, so IMEM_READ stays a function of registered state only.
  always_comb begin
    redirect_target = word_align(REDIRECT_PC);
    imem_read       = run_q && ((state_q == DRAIN) ||
                                ((state_q == FETCH) && (fifo_count != FULL_COUNT)));
    accept          = imem_read && !IMEM_BUSYWAIT;
    fifo_flush      = REDIRECT_VALID;
    fifo_push       = (state_q == FETCH) && accept && !REDIRECT_VALID;
    fifo_pop        = (state_q == FETCH) && fifo_head_valid && INSTR_READY && !REDIRECT_VALID;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= FETCH;
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= '0;
      run_q        <= 1'b0;
    end else begin
      run_q <= 1'b1;
      case (state_q)
        FETCH: begin
          if (REDIRECT_VALID) begin
            // A stalled read must keep its address, so park the target until it completes.
            if (imem_read && IMEM_BUSYWAIT) begin
              pending_pc_q <= redirect_target;
              state_q      <= DRAIN;
            end else begin
              fetch_pc_q <= redirect_target;
            end
          end else if (accept) begin
            fetch_pc_q <= fetch_pc_q + ADDR_W'(PC_STEP);
          end
        end
        DRAIN: begin
          if (!IMEM_BUSYWAIT) begin
            fetch_pc_q <= REDIRECT_VALID ? redirect_target : pending_pc_q;
            state_q    <= FETCH;
          end else if (REDIRECT_VALID) begin
            pending_pc_q <= redirect_target;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK          (CLK),
    .RESET        (RESET),
    .flush_i      (fifo_flush),
    .push_i       (fifo_push),
    .push_data_i  ({fetch_pc_q, IMEM_READDATA}),
    .pop_i        (fifo_pop),
    .head_o       (fifo_head),
    .head_valid_o (fifo_head_valid),
    .count_o      (fifo_count)
  );

  always_comb begin
    IMEM_ADDRESS = fetch_pc_q;
    IMEM_READ    = imem_read;
    INSTR_VALID  = (state_q == FETCH) && fifo_head_valid;
    INSTR        = INSTR_VALID ? fifo_head[INSTR_W-1:0] : '0;
    INSTR_PC     = INSTR_VALID ? fifo_head[ENTRY_W-1:INSTR_W] : '0;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a PC scoreboard checked on every handshake.
module tb_instr_fetch_unit;

  logic        CLK;
  logic        RESET;
  logic [31:0] IMEM_ADDRESS;
  logic        IMEM_READ;
  logic [31:0] IMEM_READDATA;
  logic        IMEM_BUSYWAIT;
  logic        REDIRECT_VALID;
  logic [31:0] REDIRECT_PC;
  logic        INSTR_VALID;
  logic [31:0] INSTR;
  logic [31:0] INSTR_PC;
  logic        INSTR_READY;

  int unsigned total;
  int unsigned bad;
  logic [31:0] sb [$];

  instr_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .IMEM_ADDRESS   (IMEM_ADDRESS),
    .IMEM_READ      (IMEM_READ),
    .IMEM_READDATA  (IMEM_READDATA),
    .IMEM_BUSYWAIT  (IMEM_BUSYWAIT),
    .REDIRECT_VALID (REDIRECT_VALID),
    .REDIRECT_PC    (REDIRECT_PC),
    .INSTR_VALID    (INSTR_VALID),
    .INSTR          (INSTR),
    .INSTR_PC       (INSTR_PC),
    .INSTR_READY    (INSTR_READY)
  );

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  assign IMEM_READDATA = memword(IMEM_ADDRESS);

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted handshake pops the next expected PC.
  always @(negedge CLK) begin
    if (!RESET && INSTR_VALID && INSTR_READY && !REDIRECT_VALID) begin
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL sb_unexpected observed_pc=%h expected=none", INSTR_PC);
      end
      if (sb.size() != 0) begin
        logic [31:0] exp_pc;
        exp_pc = sb.pop_front();
        assert (INSTR_PC === exp_pc) else begin
          bad++;
          $error("FAIL sb_pc observed=%h expected=%h", INSTR_PC, exp_pc);
        end
        assert (INSTR === memword(exp_pc)) else begin
          bad++;
          $error("FAIL sb_instr observed=%h expected=%h", INSTR, memword(exp_pc));
        end
      end
    end
  end

  task automatic reset_dut();
    RESET          = 1'b1;
    INSTR_READY    = 1'b0;
    IMEM_BUSYWAIT  = 1'b0;
    REDIRECT_VALID = 1'b0;
    REDIRECT_PC    = '0;
    sb.delete();
    tick();
    chk("rst_read", {31'd0, IMEM_READ}, 32'd0);
    chk("rst_addr", IMEM_ADDRESS, 32'h0);
    chk("rst_valid", {31'd0, INSTR_VALID}, 32'd0);
    chk("rst_instr", INSTR, 32'h0);
    chk("rst_pc", INSTR_PC, 32'h0);
    RESET = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;

    // 1: zero-wait streaming
    reset_dut();
    chk("t1_read", {31'd0, IMEM_READ}, 32'd1);
    for (int i = 0; i < 4; i++) sb.push_back(32'(i * 4));
    INSTR_READY = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t1_valid", {31'd0, INSTR_VALID}, 32'd1);
      chk("t1_pc", INSTR_PC, 32'(i * 4));
      tick();
    end
    INSTR_READY = 1'b0;

    // 2: backpressure fills the FIFO and stops reads
    reset_dut();
    chk("t2_addr0", IMEM_ADDRESS, 32'h0);
    tick();
    chk("t2_addr4", IMEM_ADDRESS, 32'h4);
    chk("t2_read4", {31'd0, IMEM_READ}, 32'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("t2_read_off", {31'd0, IMEM_READ}, 32'd0);
      chk("t2_addr_hold", IMEM_ADDRESS, 32'h8);
      chk("t2_head_pc", INSTR_PC, 32'h0);
      chk("t2_head_instr", INSTR, memword(32'h0));
      tick();
    end
    for (int i = 0; i < 4; i++) sb.push_back(32'(i * 4));
    INSTR_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_valid", {31'd0, INSTR_VALID}, 32'd1);
      chk("t2_pc", INSTR_PC, 32'(i * 4));
      tick();
    end
    INSTR_READY = 1'b0;

    // 3: stall at PC 8
    reset_dut();
    sb.push_back(32'h0);
    sb.push_back(32'h4);
    sb.push_back(32'h8);
    tick();
    tick();
    IMEM_BUSYWAIT = 1'b1;
    INSTR_READY   = 1'b1;
    chk("t3_full_read", {31'd0, IMEM_READ}, 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("t3_addr_hold", IMEM_ADDRESS, 32'h8);
      chk("t3_read_hold", {31'd0, IMEM_READ}, 32'd1);
      tick();
    end
    chk("t3_drained", {31'd0, INSTR_VALID}, 32'd0);
    IMEM_BUSYWAIT = 1'b0;
    tick();
    chk("t3_valid8", {31'd0, INSTR_VALID}, 32'd1);
    chk("t3_pc8", INSTR_PC, 32'h8);
    chk("t3_addr12", IMEM_ADDRESS, 32'hC);
    tick();
    INSTR_READY = 1'b0;

    // 4: redirect with FIFO holding 4,8; concurrent pop is ignored
    reset_dut();
    sb.push_back(32'h0);
    INSTR_READY = 1'b1;
    tick();
    tick();
    INSTR_READY = 1'b0;
    tick();
    chk("t4_head4", INSTR_PC, 32'h4);
    chk("t4_full_read", {31'd0, IMEM_READ}, 32'd0);
    REDIRECT_VALID = 1'b1;
    REDIRECT_PC    = 32'h0000_0102;
    INSTR_READY    = 1'b1;
    sb.delete();
    sb.push_back(32'h100);
    sb.push_back(32'h104);
    tick();
    REDIRECT_VALID = 1'b0;
    chk("t4_flushed", {31'd0, INSTR_VALID}, 32'd0);
    chk("t4_addr", IMEM_ADDRESS, 32'h100);
    tick();
    chk("t4_pc100", INSTR_PC, 32'h100);
    tick();
    chk("t4_pc104", INSTR_PC, 32'h104);
    tick();
    INSTR_READY = 1'b0;

    // 5: redirect during stall, retargeted while draining
    reset_dut();
    REDIRECT_VALID = 1'b1;
    REDIRECT_PC    = 32'h10;
    tick();
    REDIRECT_VALID = 1'b0;
    IMEM_BUSYWAIT  = 1'b1;
    chk("t5_addr10", IMEM_ADDRESS, 32'h10);
    REDIRECT_VALID = 1'b1;
    REDIRECT_PC    = 32'h80;
    tick();
    REDIRECT_PC = 32'h42;
    chk("t5_drain_addr", IMEM_ADDRESS, 32'h10);
    chk("t5_drain_valid", {31'd0, INSTR_VALID}, 32'd0);
    tick();
    REDIRECT_VALID = 1'b0;
    chk("t5_drain_addr2", IMEM_ADDRESS, 32'h10);
    chk("t5_drain_read", {31'd0, IMEM_READ}, 32'd1);
    IMEM_BUSYWAIT = 1'b0;
    tick();
    chk("t5_addr40", IMEM_ADDRESS, 32'h40);
    chk("t5_no_stale", {31'd0, INSTR_VALID}, 32'd0);
    sb.push_back(32'h40);
    INSTR_READY = 1'b1;
    tick();
    chk("t5_pc40", INSTR_PC, 32'h40);
    tick();
    INSTR_READY = 1'b0;

    // 6: reset while draining
    reset_dut();
    REDIRECT_VALID = 1'b1;
    REDIRECT_PC    = 32'h20;
    tick();
    IMEM_BUSYWAIT = 1'b1;
    REDIRECT_PC   = 32'h40;
    tick();
    REDIRECT_VALID = 1'b0;
    chk("t6_drain_addr", IMEM_ADDRESS, 32'h20);
    #2;
    RESET = 1'b1;
    #1;
    chk("t6_async_read", {31'd0, IMEM_READ}, 32'd0);
    chk("t6_async_addr", IMEM_ADDRESS, 32'h0);
    chk("t6_async_valid", {31'd0, INSTR_VALID}, 32'd0);
    tick();
    RESET         = 1'b0;
    IMEM_BUSYWAIT = 1'b0;
    tick();
    chk("t6_restart_addr", IMEM_ADDRESS, 32'h0);
    chk("t6_restart_read", {31'd0, IMEM_READ}, 32'd1);
    tick();
    chk("t6_restart_pc", INSTR_PC, 32'h0);
    chk("t6_restart_instr", INSTR, memword(32'h0));

    // 7: PC wraps at the top of the address space
    reset_dut();
    REDIRECT_VALID = 1'b1;
    REDIRECT_PC    = 32'hFFFF_FFFC;
    tick();
    REDIRECT_VALID = 1'b0;
    sb.push_back(32'hFFFF_FFFC);
    sb.push_back(32'h0);
    INSTR_READY = 1'b1;
    tick();
    chk("t7_pc_top", INSTR_PC, 32'hFFFF_FFFC);
    tick();
    chk("t7_pc_wrap", INSTR_PC, 32'h0);
    chk("t7_addr_wrap", IMEM_ADDRESS, 32'h4);
    tick();
    INSTR_READY = 1'b0;

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
